// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file writeback arbiter with starvation promotion and pending scoreboard (optional bypass: RF_WB_BYPASS_EN)
module rf_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    output logic            issue_stall,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
`ifdef RF_WB_BYPASS_EN
    output logic            byp1_sel,
    output logic            byp2_sel,
    output logic [XLEN-1:0] byp_data,
`endif
    output logic [31:0]     pending
);
    logic [CNT_W-1:0] r_lsu_cnt, r_mdu_cnt;
    logic [CNT_W-1:0] w_lsu_cnt_nxt, w_mdu_cnt_nxt;
    logic [31:0]      r_pending, w_pending_nxt;
    logic             w_lsu_st, w_mdu_st;
    logic             w_gnt_alu, w_gnt_lsu, w_gnt_mdu, w_any;
    logic [4:0]       w_rd;
    logic [XLEN-1:0]  w_data;
    logic             w_byp1, w_byp2, w_accept;

    // grant selection: a starved source outranks the ALU, LSU wins a double starvation
    always_comb begin
        w_lsu_st  = lsu_valid && (r_lsu_cnt == CNT_W'(STARVE_LIMIT));
        w_mdu_st  = mdu_valid && (r_mdu_cnt == CNT_W'(STARVE_LIMIT));
        w_gnt_lsu = rst && lsu_valid && (w_lsu_st || (!w_mdu_st && !alu_valid));
        w_gnt_mdu = rst && mdu_valid && !w_lsu_st && (w_mdu_st || (!alu_valid && !lsu_valid));
        w_gnt_alu = rst && alu_valid && !w_lsu_st && !w_mdu_st;
        w_any     = w_gnt_alu || w_gnt_lsu || w_gnt_mdu;
        w_rd      = w_gnt_alu ? alu_rd : w_gnt_lsu ? lsu_rd : w_gnt_mdu ? mdu_rd : 5'd0;
        w_data    = w_gnt_alu ? alu_data : w_gnt_lsu ? lsu_data : w_gnt_mdu ? mdu_data : '0;
    end

    assign alu_ready = w_gnt_alu;
    assign lsu_ready = w_gnt_lsu;
    assign mdu_ready = w_gnt_mdu;
    assign rf_wen    = w_any && (w_rd != 5'd0);
    assign rf_waddr  = w_rd;
    assign rf_wdata  = w_data;
    assign pending   = r_pending;

`ifdef RF_WB_BYPASS_EN
    // a same-cycle write to a source register is forwarded instead of stalling
    always_comb begin
        w_byp1 = rf_wen && (w_rd == issue_rs1);
        w_byp2 = rf_wen && (w_rd == issue_rs2);
    end
    assign byp1_sel = w_byp1;
    assign byp2_sel = w_byp2;
    assign byp_data = w_data;
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // hazard check and next scoreboard / starvation counter values
    always_comb begin
        issue_stall   = !rst || (issue_valid && ((r_pending[issue_rs1] && !w_byp1) ||
                                                 (r_pending[issue_rs2] && !w_byp2) ||
                                                 r_pending[issue_rd]));
        w_accept      = rst && issue_valid && !issue_stall;
        w_pending_nxt = ((r_pending & ~(w_any ? (32'd1 << w_rd) : 32'd0)) |
                         (w_accept ? (32'd1 << issue_rd) : 32'd0)) & ~32'd1;
        w_lsu_cnt_nxt = (!lsu_valid || w_gnt_lsu) ? '0 : w_lsu_st ? r_lsu_cnt : r_lsu_cnt + CNT_W'(1);
        w_mdu_cnt_nxt = (!mdu_valid || w_gnt_mdu) ? '0 : w_mdu_st ? r_mdu_cnt : r_mdu_cnt + CNT_W'(1);
    end

    // state registers, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        r_pending <= rst ? w_pending_nxt : '0;
        r_lsu_cnt <= rst ? w_lsu_cnt_nxt : '0;
        r_mdu_cnt <= rst ? w_mdu_cnt_nxt : '0;
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and random checks of rf_wb_arbiter against a priority-list reference model
module tb_rf_wb_arbiter;
    localparam int XLEN = 64;
    localparam int LIM  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 0, lsu_valid = 0, mdu_valid = 0, issue_valid = 0;
    logic [4:0]      alu_rd = 0, lsu_rd = 0, mdu_rd = 0;
    logic [XLEN-1:0] alu_data = 0, lsu_data = 0, mdu_data = 0;
    logic [4:0]      issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0;
    logic            alu_ready, lsu_ready, mdu_ready, issue_stall, rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     pending;
`ifdef RF_WB_BYPASS_EN
    logic            byp1_sel, byp2_sel;
    logic [XLEN-1:0] byp_data;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pend  = 0;
    int          m_lcnt  = 0;
    int          m_mcnt  = 0;

    rf_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_stall(issue_stall), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef RF_WB_BYPASS_EN
        .byp1_sel(byp1_sel), .byp2_sel(byp2_sel), .byp_data(byp_data),
`endif
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pb(input logic [4:0] r);
        return (r != 0) && m_pend[r];
    endfunction

    task automatic idle();
        alu_valid = 0; lsu_valid = 0; mdu_valid = 0; issue_valid = 0;
    endtask

    // one clock: check combinational outputs against the model, clock, then check the scoreboard
    task automatic step(input string tag);
        int              win;
        logic [4:0]      wrd;
        logic [XLEN-1:0] wdat;
        bit              ls, ms, b1, b2, stall, acc;
        #1;
        ls = lsu_valid && m_lcnt == LIM;
        ms = mdu_valid && m_mcnt == LIM;
        if (!rst) win = 0;
        else if (ls) win = 2;
        else if (ms) win = 3;
        else if (alu_valid) win = 1;
        else if (lsu_valid) win = 2;
        else if (mdu_valid) win = 3;
        else win = 0;
        wrd  = win == 1 ? alu_rd : win == 2 ? lsu_rd : win == 3 ? mdu_rd : 5'd0;
        wdat = win == 1 ? alu_data : win == 2 ? lsu_data : win == 3 ? mdu_data : '0;
        b1 = 0;
        b2 = 0;
`ifdef RF_WB_BYPASS_EN
        b1 = win != 0 && wrd != 0 && wrd == issue_rs1;
        b2 = win != 0 && wrd != 0 && wrd == issue_rs2;
        chk({tag, ".byp1"}, byp1_sel, b1);
        chk({tag, ".byp2"}, byp2_sel, b2);
        chk({tag, ".bypd"}, byp_data, wdat);
`endif
        stall = !rst || (issue_valid && ((pb(issue_rs1) && !b1) || (pb(issue_rs2) && !b2) || pb(issue_rd)));
        chk({tag, ".rdy"}, {alu_ready, lsu_ready, mdu_ready}, {win == 1, win == 2, win == 3});
        chk({tag, ".wen"}, rf_wen, win != 0 && wrd != 0);
        chk({tag, ".waddr"}, rf_waddr, wrd);
        chk({tag, ".wdata"}, rf_wdata, wdat);
        chk({tag, ".stall"}, issue_stall, stall);
        acc = rst && issue_valid && !stall;
        @(posedge clk);
        if (!rst) begin
            m_pend = 0; m_lcnt = 0; m_mcnt = 0;
        end else begin
            m_lcnt = (!lsu_valid || win == 2) ? 0 : (m_lcnt < LIM ? m_lcnt + 1 : LIM);
            m_mcnt = (!mdu_valid || win == 3) ? 0 : (m_mcnt < LIM ? m_mcnt + 1 : LIM);
            if (win != 0 && wrd != 0) m_pend[wrd] = 1'b0;
            if (acc && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
        @(negedge clk);
        chk({tag, ".pend"}, pending, m_pend);
    endtask

    initial begin
        // reset with every requester active
        rst = 0;
        alu_valid = 1; lsu_valid = 1; mdu_valid = 1; issue_valid = 1;
        alu_rd = 1; lsu_rd = 2; mdu_rd = 3; issue_rd = 4;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_rdy", {alu_ready, lsu_ready, mdu_ready}, 3'b000);
            chk("rst_wen", rf_wen, 1'b0);
            chk("rst_stall", issue_stall, 1'b1);
            step("rst");
        end
        chk("rst_pend", pending, 32'd0);
        rst = 1;
        idle();

        // issue rd=5, then a RAW on x5 stalls
        issue_valid = 1; issue_rs1 = 1; issue_rs2 = 2; issue_rd = 5;
        step("iss5");
        chk("p5_set", pending[5], 1'b1);
        issue_rs1 = 5; issue_rs2 = 0; issue_rd = 6;
        #1 chk("raw5", issue_stall, 1'b1);
        step("raw5");
        idle();
        alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD;
        #1;
        chk("wb5_wen", rf_wen, 1'b1);
        chk("wb5_addr", rf_waddr, 5'd5);
        chk("wb5_data", rf_wdata, 64'hDEAD);
        step("wb5");
        chk("p5_clr", pending[5], 1'b0);

        // fixed priority
        alu_valid = 1; lsu_valid = 1; mdu_valid = 1; alu_rd = 10; lsu_rd = 11; mdu_rd = 12;
        #1 chk("prio", {alu_ready, lsu_ready, mdu_ready}, 3'b100);
        step("prio");
        idle();
        step("idle");

        // LSU starvation against a continuous ALU
        alu_valid = 1; lsu_valid = 1; alu_rd = 13; lsu_rd = 14; lsu_data = 64'h55;
        for (int k = 0; k < 5; k++) begin
            #1 chk("starve", lsu_ready, k == 4);
            step("starve");
        end
        #1 chk("starve_rst", lsu_ready, 1'b0);
        step("starve_after");
        idle();

        // same-edge set and clear: set wins
        mdu_valid = 1; mdu_rd = 7; mdu_data = 64'h77;
        issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 7;
        step("same_edge");
        chk("p7_set", pending[7], 1'b1);
        idle();

        // x0 writeback and x0 destination
        alu_valid = 1; alu_rd = 0; alu_data = 64'h99;
        #1;
        chk("x0_rdy", alu_ready, 1'b1);
        chk("x0_wen", rf_wen, 1'b0);
        step("x0_wb");
        idle();
        issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        #1 chk("x0_iss", issue_stall, 1'b0);
        step("x0_iss");

        // in-flight write on a source register
        issue_rd = 3;
        step("iss3");
        alu_valid = 1; alu_rd = 3; alu_data = 64'h1234_5678;
        issue_rs1 = 0; issue_rs2 = 3; issue_rd = 9;
`ifdef RF_WB_BYPASS_EN
        #1;
        chk("byp_stall", issue_stall, 1'b0);
        chk("byp_sel2", byp2_sel, 1'b1);
        chk("byp_data", byp_data, 64'h1234_5678);
`else
        #1 chk("inflight_stall", issue_stall, 1'b1);
`endif
        step("byp");
        idle();

        // mid-operation reset discards the scoreboard
        issue_valid = 1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 20;
        step("iss20");
        idle();
        rst = 0;
        step("midrst");
        chk("midrst_pend", pending, 32'd0);
        rst = 1;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst         = $urandom_range(0, 59) != 0;
            alu_valid   = $urandom_range(0, 3) != 0;
            lsu_valid   = $urandom_range(0, 2) != 0;
            mdu_valid   = $urandom_range(0, 2) != 0;
            alu_rd      = 5'($urandom_range(0, 7));
            lsu_rd      = 5'($urandom_range(0, 7));
            mdu_rd      = 5'($urandom_range(0, 7));
            alu_data    = {$urandom, $urandom};
            lsu_data    = {$urandom, $urandom};
            mdu_data    = {$urandom, $urandom};
            issue_valid = $urandom_range(0, 1) != 0;
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Controls the single write port of the integer register file (32 x 64-bit, x0 hardwired to zero).
- Arbitrates writebacks from three sources: ALU (single-cycle), LSU (load data) and MDU (multi-cycle mul/div).
- Keeps a per-register pending scoreboard and tells the issue stage when to stall on RAW and WAW hazards.
- Sits between the execute/memory units and the register file; drives the register file's wen/waddr/wdata directly.

Parameters:
XLEN, 64, data width of the register file write port
STARVE_LIMIT, 4, consecutive lost cycles after which a lower-priority source is promoted
CNT_W, 3, width of each starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
alu_valid  in  1  ALU writeback request
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU grant
lsu_valid  in  1  LSU writeback request
lsu_rd  in  5  LSU destination register
lsu_data  in  XLEN  LSU result
lsu_ready  out  1  LSU grant
mdu_valid  in  1  MDU writeback request
mdu_rd  in  5  MDU destination register
mdu_data  in  XLEN  MDU result
mdu_ready  out  1  MDU grant
issue_valid  in  1  issue stage presents an instruction
issue_rs1  in  5  source register 1
issue_rs2  in  5  source register 2
issue_rd  in  5  destination register (0 means no write)
issue_stall  out  1  hazard; the instruction is not accepted
rf_wen  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  XLEN  register file write data
pending  out  32  scoreboard bits, for debug

Behaviour:
- Reset:
  - rst is synchronous and active-low; clock is clk.
  - While rst=0: pending=0, both starvation counters=0, all *_ready=0, rf_wen=0, rf_waddr=0, rf_wdata=0, issue_stall=1.
  - No request is granted or issued during reset. Reset applied mid-operation discards all pending state on the next edge.
- Arbitration (combinational grant; a beat transfers when valid && ready at the posedge):
  - Normal priority: ALU > LSU > MDU.
  - A starved source (counter == STARVE_LIMIT) outranks the ALU.
  - If LSU and MDU are both starved, LSU wins.
  - At most one ready is asserted per cycle.
  - A ready is asserted only when the matching valid is high.
- Write port:
  - rf_wen = any grant.
  - rf_waddr and rf_wdata are muxed from the winner; they are 0 when there is no grant.
  - A request with rd=0 is granted normally, but rf_wen is forced to 0 for that beat.
  - Latency from handshake to write is 0 cycles: the register file captures the value on the same edge.
- Starvation counters (LSU and MDU only):
  - Increment on each cycle with valid && !ready; saturate at STARVE_LIMIT.
  - Clear on grant or when valid=0.
- Scoreboard:
  - issue_stall = issue_valid && (pending[rs1] || pending[rs2] || pending[rd]). Index 0 is always treated as not pending.
  - The instruction is accepted when issue_valid && !issue_stall. On acceptance, pending[issue_rd] is set on the next edge (skipped when rd=0).
  - A granted writeback clears pending[rd] on the next edge.
  - Same-edge set and clear of the same index: set wins.
  - A writeback to a non-pending register is legal; the clear is a no-op.
  - pending[0] is held at 0.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined:
  - The current cycle's granted write is excluded from the RAW hazard check on rs1/rs2, so the instruction issues in the same cycle.
  - Adds outputs byp1_sel, byp2_sel (1 bit each) and byp_data (XLEN).
  - byp*_sel=1 when the grant's rd equals rs* (rd != 0); byp_data = rf_wdata.
  - The WAW check on rd is unchanged.
- When undefined:
  - No extra ports; a RAW match on an in-flight write stalls for that cycle.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all valids high -> all ready=0, rf_wen=0, pending=0, issue_stall=1.
- Issue then writeback:
  - Issue rd=5 (rs1=1, rs2=2) -> pending[5]=1 the next cycle.
  - A following issue with rs1=5 -> issue_stall=1.
  - ALU writeback rd=5, data 0xDEAD -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEAD, and pending[5]=0 the next cycle.
- Priority: alu/lsu/mdu all valid in one cycle -> only alu_ready=1.
- Starvation: ALU and LSU held valid continuously -> LSU loses 4 cycles, then lsu_ready=1 on the 5th cycle, and its counter returns to 0.
- Same-edge set and clear: MDU writeback rd=7 in the same cycle that an instruction with rd=7 issues -> pending[7]=1 afterwards.
- x0 handling:
  - Writeback with rd=0 -> ready=1, rf_wen=0.
  - Issue with rd=0 -> pending unchanged, no stall from rd.
  - With RF_WB_BYPASS_EN: writeback rd=3 while issuing rs2=3 -> issue_stall=0, byp2_sel=1, byp_data equals the write data.
